// File: rtl/step_controller.sv
`default_nettype none
// ============================================================================
// Module   : step_controller
// Purpose  : CPU clock-enable sequencer for cycle/instruction stepping, free
//            run with divider, and a PC breakpoint. Button debounce is compiled
//            in when the macro STEP_CONTROLLER_DEBOUNCE_EN is defined.
// Revision : 1.0
// ============================================================================
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIVIDER     = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btnStep,
  input  logic        i_swInstrNCycle,
  input  logic        i_swStepNRun,
  input  logic        i_swEnableBreakpoint,
  input  logic [15:0] i_breakpointAddress,
  input  logic [15:0] i_pc,
  input  logic        i_instrStart,
  output logic        o_cpuClkEn,
  output logic        o_running,
  output logic        o_breakHit
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_STEP_INSTR = 2'd1;
  localparam logic [1:0] ST_RUN        = 2'd2;
  localparam logic [1:0] ST_BREAK      = 2'd3;

  localparam int                DIV_W    = (RUN_DIVIDER > 1) ? $clog2(RUN_DIVIDER) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RUN_DIVIDER - 1);

  if (RUN_DIVIDER < 1 || DEBOUNCE_CYCLES < 1) begin : g_paramCheck
    $error("step_controller: RUN_DIVIDER and DEBOUNCE_CYCLES must be >= 1");
  end

  // Bit order: {breakpoint enable, run, instr/cycle, button}
  logic [3:0] r_syncStage1;
  logic [3:0] r_syncStage2;
  logic       w_btnSync;
  logic       w_swInstr;
  logic       w_swRun;
  logic       w_swBrk;
  logic       w_btnLevel;
  logic       r_btnPrev;
  logic       r_stepReq;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_syncStage1 <= '0;
      r_syncStage2 <= '0;
    end else begin
      r_syncStage1 <= {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnStep};
      r_syncStage2 <= r_syncStage1;
    end
  end

  assign w_btnSync = r_syncStage2[0];
  assign w_swInstr = r_syncStage2[1];
  assign w_swRun   = r_syncStage2[2];
  assign w_swBrk   = r_syncStage2[3];

`ifdef STEP_CONTROLLER_DEBOUNCE_EN
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DEB_W-1:0] r_debCnt;
  logic             r_btnDebounced;

  // The level is accepted once it has differed from the current one for the full interval.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_debCnt       <= '0;
      r_btnDebounced <= 1'b0;
    end else if (w_btnSync != r_btnDebounced) begin
      if (r_debCnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_debCnt       <= '0;
        r_btnDebounced <= w_btnSync;
      end else begin
        r_debCnt <= r_debCnt + DEB_W'(1);
      end
    end else begin
      r_debCnt <= '0;
    end
  end

  assign w_btnLevel = r_btnDebounced;
`else
  assign w_btnLevel = w_btnSync;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_btnPrev <= 1'b0;
      r_stepReq <= 1'b0;
    end else begin
      r_btnPrev <= w_btnLevel;
      r_stepReq <= w_btnLevel & ~r_btnPrev;
    end
  end

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_divCnt;
  logic             r_cyclePulse;
  logic             r_stepPulsed;
  logic             r_skip;
  logic             w_runSlot;
  logic             w_bpMatch;
  logic             w_runStop;

  assign w_runSlot = (r_state == ST_RUN) && (r_divCnt == '0);
  assign w_bpMatch = i_instrStart && w_swBrk && (i_pc == i_breakpointAddress) && !r_skip;
  assign w_runStop = i_instrStart && !w_swRun;

  // Enable is combinational on i_instrStart so a stop lands before the new instruction executes.
  assign o_cpuClkEn = r_cyclePulse
                    || ((r_state == ST_STEP_INSTR) && !(i_instrStart && r_stepPulsed))
                    || (w_runSlot && !w_bpMatch && !w_runStop);
  assign o_running  = (r_state == ST_RUN);
  assign o_breakHit = (r_state == ST_BREAK);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_divCnt     <= '0;
      r_cyclePulse <= 1'b0;
      r_stepPulsed <= 1'b0;
      r_skip       <= 1'b0;
    end else begin
      r_cyclePulse <= 1'b0;
      if (r_state == ST_RUN) begin
        r_divCnt <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + DIV_W'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (r_stepReq) begin
            if (w_swRun) begin
              r_state  <= ST_RUN;
              r_divCnt <= '0;
            end else if (w_swInstr) begin
              r_state      <= ST_STEP_INSTR;
              r_stepPulsed <= 1'b0;
            end else begin
              r_cyclePulse <= 1'b1;
            end
          end
        end
        ST_STEP_INSTR: begin
          if (i_instrStart && r_stepPulsed) begin
            r_state <= ST_IDLE;
          end else begin
            r_stepPulsed <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_runSlot && i_instrStart) begin
            r_skip <= 1'b0;
            if (w_bpMatch) begin
              r_state <= ST_BREAK;
            end else if (!w_swRun) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          if (!w_swRun) begin
            r_state <= ST_IDLE;
          end else if (r_stepReq) begin
            r_state  <= ST_RUN;
            r_skip   <= 1'b1;
            r_divCnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
